// File: rtl/row_loader_if.sv
// row_loader handshake and RAM write bus.
// CPU/stream side drives master; the loader uses slave.
interface row_loader_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 11
);
  logic             start;
  logic [CNT_W-1:0] pixel_count;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_enw;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, pixel_count, in_data, in_valid,
    input  in_ready, mem_address, mem_wdata,
    input  mem_enw, busy, done, error
  );

  modport slave (
    input  start, pixel_count, in_data, in_valid,
    output in_ready, mem_address, mem_wdata,
    output mem_enw, busy, done, error
  );
endinterface

// File: rtl/row_loader.sv
// Packs an R,G,B byte stream into 25-bit row words
// and writes them into the data RAM row region.
module row_loader #(
  parameter int WIDTH     = 32,
  parameter int ROW_BASE  = 2000,
  parameter int ROW_DEPTH = 1025,
  parameter int CNT_W     = 11
) (
  input  logic clk,
  input  logic rst,
  row_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, GET_R, GET_G, GET_B, WRITE, FINISH
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(ROW_DEPTH);
  localparam logic [WIDTH-1:0] BASE_C  = WIDTH'(ROW_BASE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] index_q, index_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             enw_q, enw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             last;
  logic             take;
  logic             cnt_ok;

  assign last   = (index_q == count_q - 1'b1);
  assign take   = bus.in_valid & in_ready_q;
  assign cnt_ok = (bus.pixel_count != '0) &&
                  (bus.pixel_count <= DEPTH_C);

  // Next state; outputs are decoded from the next
  // state so they leave the block as flops.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    r_d        = r_q;
    g_d        = g_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;
    in_ready_d = 1'b0;
    enw_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cnt_ok) begin
            count_d    = bus.pixel_count;
            index_d    = '0;
            error_d    = 1'b0;
            state_d    = GET_R;
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            error_d = 1'b1;
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end
      GET_R: begin
        busy_d     = 1'b1;
        in_ready_d = 1'b1;
        if (take) begin
          r_d     = bus.in_data;
          state_d = GET_G;
        end
      end
      GET_G: begin
        busy_d     = 1'b1;
        in_ready_d = 1'b1;
        if (take) begin
          g_d     = bus.in_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        busy_d = 1'b1;
        if (take) begin
          // Blue goes straight into the write word.
          state_d = WRITE;
          enw_d   = 1'b1;
          addr_d  = BASE_C + WIDTH'(index_q);
          wdata_d = WIDTH'({last, r_q, g_q, bus.in_data});
        end else begin
          in_ready_d = 1'b1;
        end
      end
      WRITE: begin
        if (last) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          index_d    = index_q + 1'b1;
          state_d    = GET_R;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      index_q    <= '0;
      r_q        <= '0;
      g_q        <= '0;
      in_ready_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      enw_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      r_q        <= r_d;
      g_q        <= g_d;
      in_ready_q <= in_ready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      enw_q      <= enw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_enw     = enw_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_row_loader.sv
// Scoreboard bench for row_loader.
// Directed loads; writes checked by a negedge monitor.
module tb_row_loader;

  localparam int WIDTH = 32;
  localparam int CNT_W = 11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   start_cyc = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  row_loader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  row_loader #(
    .WIDTH(WIDTH), .ROW_BASE(2000),
    .ROW_DEPTH(1025), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every RAM write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (bus.done) done_cnt++;
      check("ready_vs_state", bus.in_ready,
            bus.busy & ~bus.mem_enw);
      if (bus.mem_enw) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write: got addr %0d data %h, expected none",
                   bus.mem_address, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.mem_address, e.addr);
          check("wr_data", bus.mem_wdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input int k,
                                         input int mode);
    logic [7:0] v;
    if (mode == 0) v = 8'((k + 1) * 8'h11);
    else           v = 8'(k);
    return v;
  endfunction

  task automatic pulse_start(input int cnt);
    bus.start       = 1'b1;
    bus.pixel_count = CNT_W'(cnt);
    start_cyc       = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    bit ok;
    bit acc;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte %h not taken, expected taken", b);
    end
  endtask

  task automatic push_pixel(input int p, input int cnt,
                            input logic [7:0] r,
                            input logic [7:0] g,
                            input logic [7:0] b);
    wr_t e;
    e.addr = 32'(2000 + p);
    e.data = {7'b0, (p == cnt - 1), r, g, b};
    exp_q.push_back(e);
  endtask

  task automatic load_bytes(input int cnt, input int gap,
                            input int mode);
    for (int p = 0; p < cnt; p++)
      push_pixel(p, cnt, byte_of(3 * p, mode),
                 byte_of(3 * p + 1, mode),
                 byte_of(3 * p + 2, mode));
    for (int k = 0; k < 3 * cnt; k++)
      send_byte(byte_of(k, mode), gap);
    bus.in_valid = 1'b0;
  endtask

  // Latency runs from the cycle start is driven to
  // the edge on which done is sampled.
  task automatic wait_done(input int exp_lat,
                           input string name);
    int lat = -1;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      @(negedge clk);
      if (bus.done) lat = cyc + 1 - start_cyc;
    end
    check(name, lat, exp_lat);
    tick();
  endtask

  task automatic settle(input int n_done, input string name);
    repeat (4) tick();
    check({name, "_done_cnt"}, done_cnt, n_done);
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.pixel_count = '0;
    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    #1;
    check("rst_out", {bus.in_ready, bus.mem_address,
          bus.mem_wdata, bus.mem_enw, bus.busy,
          bus.done, bus.error}, '0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Two pixels, stream held valid: 4*2+2.
    pulse_start(2);
    load_bytes(2, 0, 0);
    wait_done(10, "lat_2px");
    check("err_2px", bus.error, 1'b0);
    settle(1, "t1");

    // Same load, 3 idle cycles before each byte;
    // the write cycle hides in one gap: 10+18-1.
    pulse_start(2);
    load_bytes(2, 3, 0);
    wait_done(27, "lat_gap");
    settle(2, "t2");

    // Full row region: ends at 3024 with bit 24.
    pulse_start(1025);
    load_bytes(1025, 0, 1);
    wait_done(4102, "lat_full");
    settle(3, "t3");

    // Illegal counts finish at once with error.
    pulse_start(0);
    wait_done(2, "lat_cnt0");
    check("err_cnt0", bus.error, 1'b1);
    settle(4, "t4a");
    pulse_start(1026);
    wait_done(2, "lat_cnt1026");
    check("err_cnt1026", bus.error, 1'b1);
    settle(5, "t4b");
    pulse_start(1);
    check("err_clear", bus.error, 1'b0);
    load_bytes(1, 0, 0);
    wait_done(6, "lat_1px");
    settle(6, "t4c");

    // Extra start (illegal count) mid-load is ignored.
    pulse_start(4);
    fork
      load_bytes(4, 0, 1);
      begin
        repeat (5) tick();
        bus.start       = 1'b1;
        bus.pixel_count = '0;
        tick();
        bus.start = 1'b0;
      end
    join
    wait_done(18, "lat_4px");
    check("err_4px", bus.error, 1'b0);
    settle(7, "t5");

    // Reset while pixel 3 is partly received.
    pulse_start(4);
    push_pixel(0, 4, 8'h11, 8'h22, 8'h33);
    push_pixel(1, 4, 8'h44, 8'h55, 8'h66);
    for (int k = 0; k < 7; k++)
      send_byte(byte_of(k, 0), 0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid", {bus.in_ready, bus.mem_address,
          bus.mem_wdata, bus.mem_enw, bus.busy,
          bus.done, bus.error}, '0);
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    settle(7, "t6a");
    pulse_start(1);
    push_pixel(0, 1, 8'hAA, 8'hBB, 8'hCC);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    bus.in_valid = 1'b0;
    wait_done(6, "lat_after_rst");
    settle(8, "t6b");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/row_loader.md
Name: row_loader

Overview:
- Upstream feeder for the SoC data RAM's row region (word addresses 2000-3024). The CPU starts a load with a one-cycle pulse.
- Accepts an RGB byte stream over a valid/ready handshake and packs each three-byte pixel into one 25-bit row word.
- Writes each packed word through the RAM's single write port, then pulses done.
- SoC top muxes this block's memory outputs onto the RAM port while busy=1.

Parameters:
WIDTH, 32, RAM address/data width
ROW_BASE, 2000, RAM word address of row entry 0
ROW_DEPTH, 1025, number of row entries (max pixels per load)
CNT_W, 11, width of pixel counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle load request from CPU
pixel_count  input  CNT_W  pixels to load; sampled only on accepted start
in_data  input  8  stream byte, order R,G,B per pixel
in_valid  input  1  in_data valid
in_ready  output  1  block accepts a byte this cycle
mem_address  output  WIDTH  RAM word address
mem_wdata  output  WIDTH  RAM write data
mem_enw  output  1  RAM write enable
busy  output  1  load in progress; SoC gives RAM port to this block
done  output  1  one-cycle pulse at end of load
error  output  1  sticky: last start had an illegal pixel_count

Behaviour:
- Reset values: in_ready=0, mem_address=0, mem_wdata=0, mem_enw=0, busy=0, done=0, error=0, state=IDLE, all counters 0.
- Reset is effective asynchronously at any time, including mid-load. The block returns to IDLE with no done pulse; already-written row entries are not cleared.
- All outputs are functions of registered state only. No combinational path from in_valid or start to any output.
- FSM states: IDLE, GET_R, GET_G, GET_B, WRITE, FINISH.
- IDLE, start=1, 1<=pixel_count<=ROW_DEPTH:
  - latch count, index=0, clear error;
  - next state GET_R; busy=1 from the next cycle.
- IDLE, start=1, pixel_count=0 or >ROW_DEPTH:
  - set error=1, next state FINISH;
  - no memory write occurs.
- start outside IDLE is ignored and has no effect on the load in progress.
- GET_R/GET_G/GET_B:
  - in_ready=1;
  - byte transfers on a cycle with in_valid=1 and in_ready=1; byte is stored in the R/G/B register and state advances;
  - in_valid=0 holds the state indefinitely (no timeout).
- WRITE (exactly one cycle):
  - in_ready=0, mem_enw=1;
  - mem_address=ROW_BASE+index;
  - mem_wdata={7'b0, last, R, G, B}, where last=1 iff index==count-1 (bit 24 = end-of-row flag).
  - last=1: next state FINISH. Otherwise index increments and next state is GET_R.
- FINISH (one cycle): done=1, busy=0, mem_enw=0; next state IDLE.
- mem_address and mem_wdata hold their last values outside WRITE. mem_enw=1 only in WRITE.
- busy=1 in GET_R, GET_G, GET_B and WRITE; 0 in IDLE and FINISH.
- Throughput: minimum 4 cycles per pixel (3 byte beats plus 1 write). Load latency with in_valid held high = 4*count + 2 cycles from start to done.
- Arithmetic:
  - index is CNT_W bits and never exceeds ROW_DEPTH-1, so there is no wrap-around;
  - address sum is computed at WIDTH bits, zero-extended.
- error stays set until the next accepted start, which clears or re-sets it.

Test Plan:
- Reset, start with pixel_count=2, bytes 0x11,0x22,0x33,0x44,0x55,0x66 with in_valid high -> exactly two mem writes:
  - addr 2000, data 0x00112233;
  - addr 2001, data 0x01445566;
  - done pulses 10 cycles after start; error=0.
- Same load with in_valid deasserted 3 cycles between each byte -> identical write addresses and data; in_ready never drops while in a GET state; no extra writes.
- pixel_count=1025 with incrementing bytes -> 1025 writes:
  - last write at addr 3024 with bit 24 set;
  - no write at addr 3025;
  - done once.
- pixel_count=0, then pixel_count=1026 -> error=1, done pulse 2 cycles after start, mem_enw never asserted. A following valid start with count=1 clears error.
- start pulsed again during a 4-pixel load -> ignored; exactly 4 writes (2000-2003); single done.
- rst asserted mid-byte of pixel 3 -> outputs go to reset values immediately, no further writes, no done. A fresh start then loads correctly from addr 2000.
